// File: rtl/decchk_seq.sv
// decchk_seq: steps a decimal-digit field through the external digit checker,
// one code per accepted beat, and gathers the field's error summary.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start, i_len      start request and field length (IDLE only)
//   i_abort             end the field early (RUN only)
//   i_valid, i_data     incoming digit code, o_ready accepts it
//   o_chk_value         code presented to the checker (i_data while in RUN)
//   i_chk_ok            checker verdict for o_chk_value, same cycle
//   o_busy, o_done      busy in RUN/DONE, one-cycle done pulse
//   o_aborted, o_error  held result flags of the last field
//   o_err_pos           0-based index of the first bad code
//   o_err_count         number of bad codes, saturating
module decchk_seq #(
    parameter int unsigned W    = 5,
    parameter int unsigned LENW = 6
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [LENW-1:0] i_len,
    input  logic            i_abort,
    input  logic            i_valid,
    input  logic [W-1:0]    i_data,
    output logic            o_ready,
    output logic [W-1:0]    o_chk_value,
    input  logic            i_chk_ok,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_aborted,
    output logic            o_error,
    output logic [LENW-1:0] o_err_pos,
    output logic [LENW-1:0] o_err_count
);

    localparam logic [LENW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LENW-1:0] len;
    logic [LENW-1:0] index;
    logic            accept;
    logic            last_beat;

    // Beat qualification; ready is implied by being in RUN.
    assign accept    = (state == S_RUN) && i_valid;
    assign last_beat = (index == len - LENW'(1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Abort wins regardless of whether a beat lands this cycle.
                if (i_abort || (accept && last_beat)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register; checker value follows i_data in RUN.
    always_comb begin
        o_ready     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_chk_value = '0;
        case (state)
            S_RUN: begin
                o_ready     = 1'b1;
                o_busy      = 1'b1;
                o_chk_value = i_data;
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Field length, beat index and accumulated results.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            len         <= '0;
            index       <= '0;
            o_aborted   <= 1'b0;
            o_error     <= 1'b0;
            o_err_pos   <= '0;
            o_err_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        len         <= i_len;
                        index       <= '0;
                        o_aborted   <= 1'b0;
                        o_error     <= 1'b0;
                        o_err_pos   <= '0;
                        o_err_count <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (!i_chk_ok) begin
                            if (o_err_count != CNT_MAX) begin
                                o_err_count <= o_err_count + LENW'(1);
                            end
                            if (!o_error) begin
                                o_err_pos <= index;
                                o_error   <= 1'b1;
                            end
                        end
                        // Index stays at len-1 after the final beat.
                        if (!last_beat) begin
                            index <= index + LENW'(1);
                        end
                    end
                    if (i_abort) begin
                        o_aborted <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/decchk_seq.md
Name: decchk_seq

Overview:
- Sequencer that runs a decimal-digit field through the combinational digit checker, one code per accepted beat.
- Gets a field length at start and accepts that many codes over a valid/ready handshake.
- Steers each code to the checker, then accumulates first-error position, error count and a sticky error flag.
- Sits between the 2821 buffer read path and the checker. Presents a one-cycle done pulse to the control sequencer.

Parameters:
- W, 5, width of one digit code (matches checker input).
- LENW, 6, width of field length, index and count registers.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_len  in  LENW  field length in digits; sampled with i_start.
- i_abort  in  1  terminate field early; sampled only in RUN.
- i_valid  in  1  digit code present on i_data.
- i_data  in  W  digit code.
- o_ready  out  1  sequencer accepts a code this cycle.
- o_chk_value  out  W  code presented to checker.
- i_chk_ok  in  1  checker result for o_chk_value, same cycle.
- o_busy  out  1  high in RUN and DONE.
- o_done  out  1  one-cycle pulse at end of field.
- o_aborted  out  1  last field ended by abort; held.
- o_error  out  1  at least one bad code in last field; held.
- o_err_pos  out  LENW  index (0-based) of first bad code; held.
- o_err_count  out  LENW  number of bad codes, saturating; held.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset: state goes to IDLE. o_ready, o_busy, o_done, o_aborted, o_error = 0. o_err_pos, o_err_count, internal index and length = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_ready=0, o_busy=0, o_chk_value=0.
  - i_start=1 latches i_len into len, then clears index, o_error, o_err_pos, o_err_count and o_aborted.
  - If i_len!=0, next state is RUN. If i_len==0, next state is DONE with zero results.
- RUN:
  - o_ready=1, o_busy=1. o_chk_value = i_data (combinational).
  - A beat is accepted when i_valid & o_ready.
  - On an accepted beat with i_chk_ok=0:
    - o_err_count increments, saturating at 2^LENW-1.
    - If o_error was 0: o_err_pos <= index and o_error <= 1.
  - Each accepted beat increments index. When the accepted beat has index==len-1, next state is DONE.
  - With i_valid=0: no change; the state stays in RUN indefinitely.
  - i_abort=1 with no beat accepted in the same cycle: next state DONE, o_aborted <= 1.
  - i_abort=1 with a beat accepted in the same cycle: the beat is processed first, then DONE with o_aborted=1. This applies even if it was the last beat.
  - i_start is ignored in RUN.
- DONE:
  - o_ready=0, o_busy=1, o_done=1 for exactly this one cycle. Next state IDLE unconditionally.
  - i_start in DONE is ignored.
- Latency: o_done rises on the cycle after the final beat's acceptance edge. Minimum field time is len+1 cycles from the start edge to the done cycle.
- Results: held from DONE until the next accepted i_start. The sequencer may read them any time o_busy=0.
- Synchronous reset mid-field: returns to IDLE next edge, all results cleared, no o_done pulse.
- len wrap: index never exceeds len-1. i_len of all-ones (63) is a legal maximum field.

Test Plan:
- Bench checker model: i_chk_ok = (code <= 9).
- Clean field: start len=4, codes 1,2,3,4 back-to-back. Expect o_done at cycle 5 after start, o_error=0, o_err_count=0, o_aborted=0.
- Errors with stalls: start len=6, codes 3,12,5,31,9,10 with i_valid low for 2 cycles between beats 2 and 3. Expect o_error=1, o_err_pos=1, o_err_count=3, o_ready high throughout RUN, done one cycle after beat 6.
- Zero length: start len=0. Expect o_done on the next cycle, o_busy high for 1 cycle, all results 0, o_ready never high.
- Abort: start len=8, send codes 2,15, assert i_abort with the third beat (code 4). Expect 3 beats counted, o_aborted=1, o_err_pos=1, o_err_count=1, done next cycle.
- Reset mid-field: start len=5, two beats with code 20, then pulse i_reset. Expect IDLE, o_error=0, o_err_count=0, no o_done. A new start len=1 with code 7 then completes cleanly.
- Saturation and ignored start: start len=63, all codes 31, with i_start pulsed during RUN. Expect o_err_count=63, o_err_pos=0, and the extra start has no effect.
